// File: rtl/score_draw_pkg.sv
// Shared constants and FSM state type for the score redraw sequencer.
package score_draw_pkg;

    localparam int GLYPH_W      = 20;
    localparam int GLYPH_H      = 16;
    localparam int GLYPH_PIXELS = GLYPH_W * GLYPH_H;
    localparam int GLYPH_ADDR_W = 12;

    localparam int          TENS_X_DEF    = 119;
    localparam int          UNITS_X_DEF   = 139;
    localparam int          ORIGIN_Y_DEF  = 0;
    localparam logic [2:0]  BG_COLOUR_DEF = 3'b000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        TENS  = 3'd2,
        UNITS = 3'd3,
        FLUSH = 3'd4
    } state_e;

endpackage

// File: rtl/score_draw_sequencer_if.sv
// Score control, arbiter handshake, glyph ROM and plot bus of the score redraw sequencer.
interface score_draw_sequencer_if;
    import score_draw_pkg::*;

    logic                    increment;
    logic                    clear_score;
    // draw_req is held while the sequencer wants the write port; a pixel moves
    // only in a cycle where draw_req and draw_gnt are both high, otherwise the walk stalls.
    logic                    draw_req;
    logic                    draw_gnt;
    logic [GLYPH_ADDR_W-1:0] rom_addr;
    logic [2:0]              rom_data;
    logic [7:0]              x;
    logic [6:0]              y;
    logic [2:0]              colour;
    logic                    plot;
    logic                    busy;
    logic [3:0]              score_tens;
    logic [3:0]              score_units;
    state_e                  state;

    modport master (
        output increment, clear_score, draw_gnt, rom_data,
        input  draw_req, rom_addr, x, y, colour, plot, busy, score_tens, score_units, state
    );

    modport slave (
        input  increment, clear_score, draw_gnt, rom_data,
        output draw_req, rom_addr, x, y, colour, plot, busy, score_tens, score_units, state
    );

endinterface

// File: rtl/score_draw_sequencer_bcd_score_counter.sv
// Two-digit BCD score with wrap at 99; clear wins over increment; changed flags a new value.
module bcd_score_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       increment_i,
    input  logic       clear_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o,
    output logic       changed_o
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clear_i) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (increment_i) begin
            if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens_o    = tens_q;
    assign units_o   = units_q;
    assign changed_o = (tens_d != tens_q) || (units_d != units_q);

endmodule

// File: rtl/score_draw_sequencer.sv
// Owns the BCD score and walks the tens then units glyph through the shared ROM into the plot bus.
// Optional LEADING_ZERO_BLANK_EN: a zero tens digit is walked but plotted in BG_COLOUR.
module score_draw_sequencer
    import score_draw_pkg::*;
#(
    parameter int         TENS_X    = TENS_X_DEF,
    parameter int         UNITS_X   = UNITS_X_DEF,
    parameter int         ORIGIN_Y  = ORIGIN_Y_DEF,
    parameter logic [2:0] BG_COLOUR = BG_COLOUR_DEF
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    score_draw_sequencer_if.slave bus
);

    localparam logic [7:0]              TENS_X_W   = 8'(TENS_X);
    localparam logic [7:0]              UNITS_X_W  = 8'(UNITS_X);
    localparam logic [6:0]              ORIGIN_Y_W = 7'(ORIGIN_Y);
    localparam logic [8:0]              LAST_PIX   = 9'(GLYPH_PIXELS - 1);
    localparam logic [4:0]              LAST_X     = 5'(GLYPH_W - 1);
    localparam logic [GLYPH_ADDR_W-1:0] PIX_W      = GLYPH_ADDR_W'(GLYPH_PIXELS);

    logic [3:0] score_tens, score_units;
    logic       score_changed;

    state_e     state_q, state_d;
    logic       dirty_q, dirty_d;
    logic [3:0] snap_tens_q, snap_tens_d;
    logic [3:0] snap_units_q, snap_units_d;
    logic [8:0] p_q, p_d;
    logic [4:0] xo_q, xo_d;
    logic [3:0] yo_q, yo_d;
    logic       plot_q, plot_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       blank_q, blank_d;
    logic [3:0] digit_sel;

    bcd_score_counter u_score (
        .clk_i       (CLOCK_50),
        .rst_i       (reset),
        .increment_i (bus.increment),
        .clear_i     (bus.clear_score),
        .tens_o      (score_tens),
        .units_o     (score_units),
        .changed_o   (score_changed)
    );

    always_comb begin
        state_d      = state_q;
        dirty_d      = dirty_q | score_changed;
        snap_tens_d  = snap_tens_q;
        snap_units_d = snap_units_q;
        p_d          = p_q;
        xo_d         = xo_q;
        yo_d         = yo_q;
        plot_d       = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        blank_d      = blank_q;
        unique case (state_q)
            IDLE: begin
                if (dirty_q) begin
                    state_d      = REQ;
                    snap_tens_d  = score_tens;
                    snap_units_d = score_units;
                    // A change landing in the snapshot cycle must still trigger another redraw.
                    dirty_d      = score_changed;
                    p_d          = 9'd0;
                    xo_d         = 5'd0;
                    yo_d         = 4'd0;
                end
            end
            REQ: begin
                if (bus.draw_gnt) state_d = TENS;
            end
            TENS, UNITS: begin
                if (bus.draw_gnt) begin
                    plot_d = 1'b1;
                    x_d    = ((state_q == TENS) ? TENS_X_W : UNITS_X_W) + {3'b000, xo_q};
                    y_d    = ORIGIN_Y_W + {3'b000, yo_q};
`ifdef LEADING_ZERO_BLANK_EN
                    blank_d = (state_q == TENS) && (snap_tens_q == 4'd0);
`else
                    blank_d = 1'b0;
`endif
                    if (p_q == LAST_PIX) begin
                        p_d     = 9'd0;
                        xo_d    = 5'd0;
                        yo_d    = 4'd0;
                        state_d = (state_q == TENS) ? UNITS : FLUSH;
                    end else begin
                        p_d = p_q + 9'd1;
                        if (xo_q == LAST_X) begin
                            xo_d = 5'd0;
                            yo_d = yo_q + 4'd1;
                        end else begin
                            xo_d = xo_q + 5'd1;
                        end
                    end
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= IDLE;
            dirty_q      <= 1'b1;
            snap_tens_q  <= 4'd0;
            snap_units_q <= 4'd0;
            p_q          <= 9'd0;
            xo_q         <= 5'd0;
            yo_q         <= 4'd0;
            plot_q       <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            blank_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dirty_q      <= dirty_d;
            snap_tens_q  <= snap_tens_d;
            snap_units_q <= snap_units_d;
            p_q          <= p_d;
            xo_q         <= xo_d;
            yo_q         <= yo_d;
            plot_q       <= plot_d;
            x_q          <= x_d;
            y_q          <= y_d;
            blank_q      <= blank_d;
        end
    end

    // ROM data returns one cycle after the address, i.e. alongside the registered plot.
    assign digit_sel       = (state_q == UNITS) ? snap_units_q : snap_tens_q;
    assign bus.rom_addr    = {8'd0, digit_sel} * PIX_W + {3'd0, p_q};
    assign bus.colour      = plot_q ? (blank_q ? BG_COLOUR : bus.rom_data) : 3'b000;
    assign bus.plot        = plot_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.draw_req    = (state_q == REQ) || (state_q == TENS) || (state_q == UNITS);
    assign bus.busy        = (state_q != IDLE);
    assign bus.score_tens  = score_tens;
    assign bus.score_units = score_units;
    assign bus.state       = state_q;

endmodule
